// File: rtl/lcd_status_display.sv
// lcd_status_display: write-only HD44780 controller for the DE2 16x2 LCD.
// Runs the power-on init itself, then redraws a status line and a hex value
// line whenever the status flags or DATA differ from the last drawn snapshot.
module lcd_status_display #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned POWERON_CYC = 1_000_000,
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned PULSE_CYC   = 25,
    parameter int unsigned WAIT_CYC    = 2_500,
    parameter int unsigned CLEAR_CYC   = 100_000
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              isHalt,
    input  logic              isBios,
    input  logic              isTransf,
    input  logic              isInsert,
    input  logic [DATA_W-1:0] DATA,
    output logic [7:0]        LCD_DATA,
    output logic              LCD_RS,
    output logic              LCD_E,
    output logic              LCD_RW,
    output logic              LCD_ON,
    output logic              LCD_BLON,
    output logic              oREADY,
    output logic              oBUSY
);

    localparam int unsigned NDIG    = DATA_W / 4;
    localparam int unsigned SNAP_W  = DATA_W + 4;
    localparam int unsigned MAX_A   = (POWERON_CYC > CLEAR_CYC) ? POWERON_CYC : CLEAR_CYC;
    localparam int unsigned MAX_B   = (WAIT_CYC > PULSE_CYC) ? WAIT_CYC : PULSE_CYC;
    localparam int unsigned MAX_C   = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] PWRON_LAST = CNT_W'(POWERON_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYC - 1);

    // 16-character lines, first character in the top byte
    localparam logic [127:0] TXT_HALT   = {"HALT", {12{8'h20}}};
    localparam logic [127:0] TXT_BIOS   = {"BIOS", {12{8'h20}}};
    localparam logic [127:0] TXT_TRANSF = {"TRANSFER", {8{8'h20}}};
    localparam logic [127:0] TXT_INSERT = {"INSERT DATA", {5{8'h20}}};
    localparam logic [127:0] TXT_RUN    = {"RUNNING", {9{8'h20}}};
    localparam logic [127:0] TXT_L2     = {"0x", {14{8'h20}}};

    typedef enum logic [2:0] {S_PWRON, S_INIT, S_SNAP, S_FRAME, S_IDLE} state_t;
    typedef enum logic [1:0] {W_SETUP, W_PULSE, W_WAIT} wphase_t;

    state_t             state_q;
    wphase_t            wph_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [5:0]         idx_q;
    logic [SNAP_W-1:0]  snap_q;

    logic [5:0]         nxt_idx_d;
    logic [127:0]       line1_d;
    logic [127:0]       line2_d;
    logic [3:0]         pos1_d;
    logic [3:0]         pos2_d;
    logic [7:0]         frame_byte_d;
    logic               frame_rs_d;
    logic [7:0]         init_byte_d;
    logic [CNT_W-1:0]   wait_last_d;
    logic [SNAP_W-1:0]  live_d;

    assign LCD_RW   = 1'b0;
    assign LCD_ON   = 1'b1;
    assign LCD_BLON = 1'b1;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // Byte/RS of the next write and the wait length of the current one
    always_comb begin
        nxt_idx_d = idx_q + 6'd1;
        live_d    = {isHalt, isBios, isTransf, isInsert, DATA};

        if (snap_q[SNAP_W-1])      line1_d = TXT_HALT;
        else if (snap_q[SNAP_W-2]) line1_d = TXT_BIOS;
        else if (snap_q[SNAP_W-3]) line1_d = TXT_TRANSF;
        else if (snap_q[SNAP_W-4]) line1_d = TXT_INSERT;
        else                       line1_d = TXT_RUN;

        line2_d = TXT_L2;
        for (int unsigned n = 0; n < NDIG; n++) begin
            line2_d[8*(13-n) +: 8] = hex_char(snap_q[4*(NDIG-1-n) +: 4]);
        end

        // write index 0 = 0x80, 1..16 = line 1, 17 = 0xC0, 18..33 = line 2
        pos1_d       = 4'(nxt_idx_d - 6'd1);
        pos2_d       = 4'(nxt_idx_d - 6'd18);
        frame_rs_d   = 1'b1;
        if (nxt_idx_d <= 6'd16) begin
            frame_byte_d = line1_d[{~pos1_d, 3'b000} +: 8];
        end else if (nxt_idx_d == 6'd17) begin
            frame_byte_d = 8'hC0;
            frame_rs_d   = 1'b0;
        end else begin
            frame_byte_d = line2_d[{~pos2_d, 3'b000} +: 8];
        end

        case (nxt_idx_d[1:0])
            2'd1:    init_byte_d = 8'h0C;
            2'd2:    init_byte_d = 8'h01;
            2'd3:    init_byte_d = 8'h06;
            default: init_byte_d = 8'h38;
        endcase

        wait_last_d = (state_q == S_INIT && idx_q == 6'd2) ? CLEAR_LAST : WAIT_LAST;
    end

    // Sequencer: power-on wait, init commands, snapshot, frame writes, idle compare
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= S_PWRON;
            wph_q    <= W_SETUP;
            cnt_q    <= '0;
            idx_q    <= '0;
            snap_q   <= '0;
            LCD_DATA <= 8'h00;
            LCD_RS   <= 1'b0;
            LCD_E    <= 1'b0;
            oREADY   <= 1'b0;
            oBUSY    <= 1'b1;
        end else begin
            case (state_q)
                S_PWRON: begin
                    if (cnt_q == PWRON_LAST) begin
                        state_q  <= S_INIT;
                        wph_q    <= W_SETUP;
                        cnt_q    <= '0;
                        idx_q    <= '0;
                        LCD_DATA <= 8'h38;
                        LCD_RS   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_INIT, S_FRAME: begin
                    case (wph_q)
                        W_SETUP: begin
                            if (cnt_q == SETUP_LAST) begin
                                wph_q <= W_PULSE;
                                cnt_q <= '0;
                                LCD_E <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                        W_PULSE: begin
                            if (cnt_q == PULSE_LAST) begin
                                wph_q <= W_WAIT;
                                cnt_q <= '0;
                                LCD_E <= 1'b0;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                        default: begin
                            if (cnt_q == wait_last_d) begin
                                wph_q <= W_SETUP;
                                cnt_q <= '0;
                                if (state_q == S_INIT) begin
                                    if (idx_q == 6'd3) begin
                                        state_q <= S_SNAP;
                                        oREADY  <= 1'b1;
                                    end else begin
                                        idx_q    <= nxt_idx_d;
                                        LCD_DATA <= init_byte_d;
                                        LCD_RS   <= 1'b0;
                                    end
                                end else begin
                                    if (idx_q == 6'd33) begin
                                        state_q <= S_IDLE;
                                        oBUSY   <= 1'b0;
                                    end else begin
                                        idx_q    <= nxt_idx_d;
                                        LCD_DATA <= frame_byte_d;
                                        LCD_RS   <= frame_rs_d;
                                    end
                                end
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    endcase
                end

                S_SNAP: begin
                    snap_q   <= live_d;
                    state_q  <= S_FRAME;
                    wph_q    <= W_SETUP;
                    cnt_q    <= '0;
                    idx_q    <= '0;
                    LCD_DATA <= 8'h80;
                    LCD_RS   <= 1'b0;
                end

                S_IDLE: begin
                    if (live_d != snap_q) begin
                        state_q <= S_SNAP;
                        oBUSY   <= 1'b1;
                    end
                end

                default: state_q <= S_PWRON;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_status_display.sv
// Testbench for lcd_status_display: captures every LCD write and checks it
// against frames built from the display rules with strings.
module tb_lcd_status_display;

    localparam int PON = 20;
    localparam int SU  = 2;
    localparam int PW  = 4;
    localparam int WT  = 6;
    localparam int CLR = 20;
    localparam int FRAME_CYC = 1 + 34 * (SU + PW + WT);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst8_n;
    logic        halt, bios, transf, insert;
    logic [31:0] data;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_e, lcd_rw, lcd_on, lcd_blon, ready, busy;

    logic        z8;
    logic [7:0]  data8;
    logic [7:0]  lcd_data8;
    logic        lcd_rs8, lcd_e8, lcd_rw8, lcd_on8, lcd_blon8, ready8, busy8;

    lcd_status_display #(
        .DATA_W(32), .POWERON_CYC(PON), .SETUP_CYC(SU), .PULSE_CYC(PW),
        .WAIT_CYC(WT), .CLEAR_CYC(CLR)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n), .isHalt(halt), .isBios(bios),
        .isTransf(transf), .isInsert(insert), .DATA(data),
        .LCD_DATA(lcd_data), .LCD_RS(lcd_rs), .LCD_E(lcd_e), .LCD_RW(lcd_rw),
        .LCD_ON(lcd_on), .LCD_BLON(lcd_blon), .oREADY(ready), .oBUSY(busy)
    );

    lcd_status_display #(
        .DATA_W(8), .POWERON_CYC(PON), .SETUP_CYC(SU), .PULSE_CYC(PW),
        .WAIT_CYC(WT), .CLEAR_CYC(CLR)
    ) dut8 (
        .iCLK(clk), .iRST_N(rst8_n), .isHalt(z8), .isBios(z8),
        .isTransf(z8), .isInsert(z8), .DATA(data8),
        .LCD_DATA(lcd_data8), .LCD_RS(lcd_rs8), .LCD_E(lcd_e8), .LCD_RW(lcd_rw8),
        .LCD_ON(lcd_on8), .LCD_BLON(lcd_blon8), .oREADY(ready8), .oBUSY(busy8)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int ready_stamp = 0;

    logic [8:0] cap_q[$];
    int         rise_q[$];
    logic [8:0] cap8_q[$];
    logic [8:0] got[34];
    int         got_rise[34];
    logic [8:0] exp_frame[34];

    // Bus monitor: records writes and checks strobe width and bus stability
    logic       e_prev = 1'b0;
    int         hi_len = 0;
    int         stable = 0;
    logic [8:0] bus_prev = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            e_prev = 1'b0; hi_len = 0; stable = 0; bus_prev = '0;
        end else begin
            if (lcd_e && !e_prev) begin
                cap_q.push_back({lcd_rs, lcd_data});
                rise_q.push_back(cyc);
                checks++;
                if (stable < SU) begin
                    errors++;
                    $display("FAIL setup: bus stable %0d cycles before E rise, required >= %0d", stable, SU);
                end
            end
            if (lcd_e && e_prev) begin
                checks++;
                if ({lcd_rs, lcd_data} !== bus_prev) begin
                    errors++;
                    $display("FAIL bus_hold: bus %03h while E high, required %03h", {lcd_rs, lcd_data}, bus_prev);
                end
            end
            if (lcd_e) hi_len++;
            if (!lcd_e && e_prev) begin
                checks++;
                if (hi_len != PW) begin
                    errors++;
                    $display("FAIL pulse_width: E high %0d cycles, required %0d", hi_len, PW);
                end
                hi_len = 0;
            end
            if ({lcd_rs, lcd_data} !== bus_prev) stable = 1;
            else stable++;
            bus_prev = {lcd_rs, lcd_data};
            e_prev   = lcd_e;
        end
    end

    logic e8_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst8_n) e8_prev = 1'b0;
        else begin
            if (lcd_e8 && !e8_prev) cap8_q.push_back({lcd_rs8, lcd_data8});
            e8_prev = lcd_e8;
        end
    end

    // Reference frame: 0x80, status text, 0xC0, "0x" + hex text, all padded
    task automatic make_expect(input logic [3:0] f, input string hx);
        string l1, l2;
        if (f[3])      l1 = "HALT";
        else if (f[2]) l1 = "BIOS";
        else if (f[1]) l1 = "TRANSFER";
        else if (f[0]) l1 = "INSERT DATA";
        else           l1 = "RUNNING";
        l2 = {"0x", hx};
        while (l1.len() < 16) l1 = {l1, " "};
        while (l2.len() < 16) l2 = {l2, " "};
        exp_frame[0] = 9'h080;
        for (int k = 0; k < 16; k++) exp_frame[1 + k] = {1'b1, l1[k]};
        exp_frame[17] = 9'h0C0;
        for (int k = 0; k < 16; k++) exp_frame[18 + k] = {1'b1, l2[k]};
    endtask

    function automatic string hex32(input logic [31:0] d);
        string s;
        s = $sformatf("%08h", d);
        return s.toupper();
    endfunction

    task automatic wait_writes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cap_q.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic get_frame(input int budget, output bit ok);
        wait_writes(34, budget, ok);
        if (ok) begin
            for (int k = 0; k < 34; k++) begin
                got[k]      = cap_q.pop_front();
                got_rise[k] = rise_q.pop_front();
            end
        end
    endtask

    task automatic wait_busy_low(input int budget, output bit ok, output int stamp);
        ok = 1'b0; stamp = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; stamp = cyc; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({lcd_e, lcd_rs, lcd_data, ready, busy} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs: E=%b RS=%b DATA=%02h RDY=%b BUSY=%b, required 0 0 00 0 1",
                     lcd_e, lcd_rs, lcd_data, ready, busy);
        end
        checks++;
        if ({lcd_rw, lcd_on, lcd_blon} !== 3'b011) begin
            errors++;
            $display("FAIL tie_offs: RW/ON/BLON=%b, required 011", {lcd_rw, lcd_on, lcd_blon});
        end
    endtask

    // Release reset with inputs at 0; change inputs mid-init to (f, d)
    task automatic test_init(input string tag, input logic [3:0] f, input logic [31:0] d);
        bit ok;
        int rel;
        logic [7:0] cmds[4];
        cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h01; cmds[3] = 8'h06;
        {halt, bios, transf, insert} = 4'b0000;
        data = 32'h0;
        @(negedge clk);
        cap_q.delete(); rise_q.delete();
        rst_n = 1'b1;
        rel = cyc;
        wait_writes(1, 200, ok);
        {halt, bios, transf, insert} = f;
        data = d;
        wait_writes(4, 300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: %0d init writes seen, required 4", tag, cap_q.size());
            return;
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_early: oREADY=%b during init, required 0", tag, ready);
        end
        checks++;
        if (rise_q[0] != rel + PON + SU) begin
            errors++;
            $display("FAIL %s_first_E: E rose at cycle %0d, required %0d", tag, rise_q[0] - rel, PON + SU);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cap_q[k] !== {1'b0, cmds[k]}) begin
                errors++;
                $display("FAIL %s_cmd[%0d]: got %03h, required %03h", tag, k, cap_q[k], {1'b0, cmds[k]});
            end
        end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (rise_q[k] - rise_q[k-1] != PW + ((k == 3) ? CLR : WT) + SU) begin
                errors++;
                $display("FAIL %s_gap[%0d]: %0d cycles between E rises, required %0d",
                         tag, k, rise_q[k] - rise_q[k-1], PW + ((k == 3) ? CLR : WT) + SU);
            end
        end
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready) begin ok = 1'b1; ready_stamp = cyc; break; end
        end
        checks++;
        if (!ok || ready_stamp != rise_q[3] + PW + WT) begin
            errors++;
            $display("FAIL %s_ready: oREADY rise ok=%0b at %0d, required %0d",
                     tag, ok, ready_stamp - rise_q[3], PW + WT);
        end
        for (int k = 0; k < 4; k++) begin
            void'(cap_q.pop_front());
            void'(rise_q.pop_front());
        end
    endtask

    task automatic test_first_frame(input string tag);
        bit ok;
        int st;
        make_expect({halt, bios, transf, insert}, hex32(data));
        get_frame(700, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: %0d writes seen, required 34", tag, cap_q.size());
            return;
        end
        for (int k = 0; k < 34; k++) begin
            checks++;
            if (got[k] !== exp_frame[k]) begin
                errors++;
                $display("FAIL %s[%0d]: got %03h, required %03h", tag, k, got[k], exp_frame[k]);
            end
        end
        checks++;
        if (got_rise[0] != ready_stamp + 1 + SU) begin
            errors++;
            $display("FAIL %s_latency: first E %0d after ready, required %0d", tag, got_rise[0] - ready_stamp, 1 + SU);
        end
        wait_busy_low(200, ok, st);
        checks++;
        if (!ok || st != ready_stamp + FRAME_CYC) begin
            errors++;
            $display("FAIL %s_length: oBUSY fell ok=%0b at %0d, required %0d", tag, ok, st - ready_stamp, FRAME_CYC);
        end
    endtask

    task automatic test_idle_change();
        bit ok;
        int st, tsnap;
        @(negedge clk);
        {halt, bios, transf, insert} = 4'b0010;
        @(negedge clk);
        tsnap = cyc;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL idle_busy: oBUSY=%b one cycle after change, required 1", busy);
        end
        make_expect(4'b0010, hex32(data));
        get_frame(700, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_timeout: %0d writes seen, required 34", cap_q.size());
            return;
        end
        for (int k = 0; k < 34; k++) begin
            checks++;
            if (got[k] !== exp_frame[k]) begin
                errors++;
                $display("FAIL idle_frame[%0d]: got %03h, required %03h", k, got[k], exp_frame[k]);
            end
        end
        checks++;
        if (got_rise[0] != tsnap + 1 + SU) begin
            errors++;
            $display("FAIL idle_latency: first E %0d after snap, required %0d", got_rise[0] - tsnap, 1 + SU);
        end
        wait_busy_low(200, ok, st);
        checks++;
        if (!ok || st != tsnap + FRAME_CYC) begin
            errors++;
            $display("FAIL idle_length: oBUSY fell ok=%0b at %0d, required %0d", ok, st - tsnap, FRAME_CYC);
        end
        repeat (1000) @(negedge clk);
        checks++;
        if (cap_q.size() != 0) begin
            errors++;
            $display("FAIL idle_quiet: %0d writes with unchanged inputs, required 0", cap_q.size());
        end
    endtask

    task automatic test_random_frames();
        bit ok;
        int st;
        logic [3:0]  f;
        logic [31:0] d;
        for (int it = 0; it < 4; it++) begin
            f = (it == 0) ? 4'b0000 : (it == 1) ? 4'b0001 : 4'($urandom_range(0, 15));
            d = $urandom;
            if (d == data) d = ~d;
            @(negedge clk);
            {halt, bios, transf, insert} = f;
            data = d;
            make_expect(f, hex32(d));
            get_frame(700, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rand%0d_timeout: %0d writes seen, required 34", it, cap_q.size());
                return;
            end
            for (int k = 0; k < 34; k++) begin
                checks++;
                if (got[k] !== exp_frame[k]) begin
                    errors++;
                    $display("FAIL rand%0d[%0d]: got %03h, required %03h (flags %b data %08h)",
                             it, k, got[k], exp_frame[k], f, d);
                end
            end
            wait_busy_low(200, ok, st);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rand%0d_busy: oBUSY stuck at %b, required 0", it, busy);
            end
        end
    endtask

    task automatic test_mid_frame();
        bit ok;
        int st;
        logic [31:0] d1;
        d1 = $urandom;
        while (d1 == data || d1 == 32'hFFFFFFFF) d1 = d1 + 32'd1;
        @(negedge clk);
        data = d1;
        wait_writes(10, 300, ok);
        data = 32'hFFFFFFFF;
        for (int fr = 0; fr < 2; fr++) begin
            make_expect({halt, bios, transf, insert}, hex32((fr == 0) ? d1 : 32'hFFFFFFFF));
            get_frame(700, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL mid%0d_timeout: %0d writes seen, required 34", fr, cap_q.size());
                return;
            end
            for (int k = 0; k < 34; k++) begin
                checks++;
                if (got[k] !== exp_frame[k]) begin
                    errors++;
                    $display("FAIL mid%0d[%0d]: got %03h, required %03h", fr, k, got[k], exp_frame[k]);
                end
            end
        end
        wait_busy_low(200, ok, st);
        repeat (300) @(negedge clk);
        checks++;
        if (cap_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_extra: %0d writes after second frame, busy=%b, required 0 and 0", cap_q.size(), busy);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        @(negedge clk);
        data = data ^ 32'h0F0F_0001;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (lcd_e) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstmid_timeout: E never rose, required a pulse");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({lcd_e, lcd_rs, lcd_data, ready, busy} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_async: E=%b RS=%b DATA=%02h RDY=%b BUSY=%b, required 0 0 00 0 1",
                     lcd_e, lcd_rs, lcd_data, ready, busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_width8();
        bit ok;
        string s;
        logic [7:0] cmds[4];
        cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h01; cmds[3] = 8'h06;
        @(negedge clk);
        rst8_n = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (cap8_q.size() >= 38) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL w8_timeout: %0d writes seen, required 38", cap8_q.size());
            return;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cap8_q[k] !== {1'b0, cmds[k]}) begin
                errors++;
                $display("FAIL w8_cmd[%0d]: got %03h, required %03h", k, cap8_q[k], {1'b0, cmds[k]});
            end
        end
        s = $sformatf("%02h", data8);
        make_expect(4'b0000, s.toupper());
        for (int k = 0; k < 34; k++) begin
            checks++;
            if (cap8_q[4 + k] !== exp_frame[k]) begin
                errors++;
                $display("FAIL w8_frame[%0d]: got %03h, required %03h", k, cap8_q[4 + k], exp_frame[k]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; rst8_n = 1'b0;
        {halt, bios, transf, insert} = 4'b0000;
        data = 32'h0; z8 = 1'b0; data8 = 8'h0F;
        test_reset();
        test_init("init", 4'b1100, 32'h1234ABCD);
        test_first_frame("first_frame");
        test_idle_change();
        test_random_frames();
        test_mid_frame();
        test_reset_mid();
        test_init("reinit", 4'b0001, 32'hCAFE_0123);
        test_first_frame("reinit_frame");
        test_width8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_status_display.md
# lcd_status_display

Parametrised write-only HD44780 controller for the DE2 16x2 character LCD. It performs the power-on init sequence itself, then shows a prioritised CPU status message on line 1 and a hex value of DATA on line 2. It redraws the screen only when the inputs change. It sits between the CPU status flags / data word and the LCD pins, and needs no separate reset-delay block.

## Interface
- DATA_W, 32, width of DATA; multiple of 4, range 4..56 (shown as DATA_W/4 hex digits)
- POWERON_CYC, 1_000_000, idle cycles after reset before first command (20 ms at 50 MHz)
- SETUP_CYC, 4, cycles RS/DATA are stable with E low before E rises
- PULSE_CYC, 25, cycles E is held high
- WAIT_CYC, 2_500, cycles after E falls for normal commands and characters
- CLEAR_CYC, 100_000, cycles after E falls for the 0x01 clear command

Ports:
- iCLK  in  1  system clock
- iRST_N  in  1  asynchronous, active-low reset
- isHalt, isBios, isTransf, isInsert  in  1 each  CPU status flags
- DATA  in  DATA_W  value to display
- LCD_DATA  out  8  LCD data bus
- LCD_RS  out  1  0 = command, 1 = character
- LCD_E  out  1  LCD enable strobe
- LCD_RW  out  1  tied to 0 (write only)
- LCD_ON, LCD_BLON  out  1 each  tied to 1
- oREADY  out  1  init sequence finished
- oBUSY  out  1  init or frame write in progress

## Operation
- Reset values: LCD_DATA = 0x00, LCD_RS = 0, LCD_E = 0, oREADY = 0, oBUSY = 1; state = PWRON.
- PWRON: count POWERON_CYC cycles, then go to INIT.
- INIT: write the commands 0x38, 0x0C, 0x01, 0x06 in that order. The 0x01 command uses CLEAR_CYC; all others use WAIT_CYC. Afterwards set oREADY = 1 and go to SNAP. oREADY stays 1 until the next reset.
- Write primitive, every command or character:
  - SETUP_CYC cycles: LCD_RS/LCD_DATA driven, LCD_E = 0.
  - PULSE_CYC cycles: LCD_E = 1.
  - WAIT_CYC (or CLEAR_CYC) cycles: LCD_E = 0.
  - LCD_RS/LCD_DATA hold until the next write begins.
- SNAP (1 cycle): latch the four flags and DATA into a snapshot register. Go to FRAME.
- FRAME: 34 writes in this order, then go to IDLE:
  - command 0x80, then 16 line-1 characters;
  - command 0xC0, then 16 line-2 characters.
- Line 1 text is selected from the snapshot by priority, each string space-padded to 16 characters:
  - isHalt: "HALT"
  - else isBios: "BIOS"
  - else isTransf: "TRANSFER"
  - else isInsert: "INSERT DATA"
  - else: "RUNNING"
- Line 2 text: "0x", then DATA_W/4 hex digits MSB-first, space-padded to 16 characters.
  - Digit 0..9 encodes as 0x30..0x39.
  - Digit A..F encodes as 0x41..0x46 (uppercase).
- IDLE: oBUSY = 0. Each cycle, compare the live inputs with the snapshot. On any difference, go to SNAP on the next edge with oBUSY = 1.
- Input changes during FRAME are ignored mid-frame; the frame uses the snapshot only. The IDLE compare then triggers exactly one further frame.
- Input changes during PWRON/INIT are not lost: the first frame always runs after INIT.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous), LCD_E drops at once, and the sequence restarts from PWRON.

## Timing
- Write length: SETUP_CYC + PULSE_CYC + WAIT_CYC cycles, or SETUP_CYC + PULSE_CYC + CLEAR_CYC for the clear command.
- Frame length: 1 (SNAP) + 34 × (SETUP_CYC + PULSE_CYC + WAIT_CYC) cycles.
- Latency from an input change in IDLE to the SNAP state: 1 cycle. The first LCD_E rise follows SETUP_CYC cycles later.
- LCD_E is high for exactly PULSE_CYC consecutive cycles per write. LCD_RS/LCD_DATA never change while LCD_E = 1, nor within SETUP_CYC cycles before LCD_E rises.
- Counter widths must hold max(POWERON_CYC, CLEAR_CYC) without wrap.

## Test plan
Bench parameters: POWERON_CYC=20, SETUP_CYC=2, PULSE_CYC=4, WAIT_CYC=6, CLEAR_CYC=20, DATA_W=32.

- Reset release with all flags 0 and DATA = 0 -> LCD_E stays 0 for 20 cycles; then exactly 4 E pulses carrying 0x38, 0x0C, 0x01, 0x06 with RS = 0; the gap after 0x01 is 20 cycles; oREADY rises after the 4th write.
- First frame with DATA = 0x1234ABCD, isHalt = 1, isBios = 1 -> byte capture shows 0x80, "HALT" + 12 spaces, 0xC0, "0x1234ABCD" + 6 spaces; RS = 0 only on 0x80/0xC0; frame takes 1 + 34×12 = 409 cycles; oBUSY falls at the end.
- In IDLE, set isTransf = 1 (others 0) -> oBUSY rises the next cycle; a new frame shows "TRANSFER" on line 1; afterwards with no change there are no more E pulses for ≥1000 cycles.
- Change DATA to 0xFFFFFFFF in the middle of a frame -> the current frame finishes with the old value; exactly one extra frame shows "0xFFFFFFFF".
- Assert iRST_N = 0 while LCD_E = 1 -> LCD_E, LCD_RS and oREADY go to 0 and LCD_DATA to 0x00 without waiting for a clock edge; after release the full init sequence repeats.
- With DATA_W=8 and DATA = 0x0F -> line 2 is "0x0F" + 12 spaces.
